unit_norm_round: RTL and testbench

UNIT_NORM_ROUND -- requirements
Module: unit_norm_round

---
 rtl/unit_norm_round.sv | 155 +++++++++++++++
 tb/tb_unit_norm_round.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unit_norm_round.sv
// Normalizes and rounds a raw single-precision adder sum to IEEE-754, round to nearest even.
// One operand in flight: accept in idle, shift left one bit per cycle, round, hold until taken.
module unit_norm_round (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [28:0] i_sum,
    input  logic [7:0]  i_exp,
    input  logic        i_sign,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic        o_ovf,
    output logic        o_udf
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StRound,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [28:0] sum_q, sum_d;
    logic [8:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;
    logic        valid_q, valid_d;
    logic        ready_q, ready_d;

    logic [22:0] frac;
    logic        guard_bit;
    logic        round_bit;
    logic        sticky_bit;
    logic        round_up;
    logic [23:0] frac_inc;
    logic [8:0]  exp_rnd;

    // Rounding datapath on the normalized mantissa (bit27 is the hidden one).
    always_comb begin
        frac       = sum_q[26:4];
        guard_bit  = sum_q[3];
        round_bit  = sum_q[2];
        sticky_bit = |sum_q[1:0];
        round_up   = guard_bit & (round_bit | sticky_bit | sum_q[4]);
        frac_inc   = {1'b0, frac} + {23'b0, round_up};
        // exp_q may already be 255 after a carry shift; the 9th bit keeps 256 distinct.
        exp_rnd    = exp_q + {8'b0, frac_inc[23]};
    end

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    sign_d = i_sign;
                    ovf_d  = 1'b0;
                    udf_d  = 1'b0;
                    exp_d  = {1'b0, i_exp};
                    if (i_sum == 29'd0) begin
                        sum_d    = '0;
                        result_d = 32'h0000_0000;
                        state_d  = StDone;
                    end else if (i_sum[28]) begin
                        sum_d   = {1'b0, i_sum[28:2], i_sum[1] | i_sum[0]};
                        exp_d   = {1'b0, i_exp} + 9'd1;
                        state_d = StRound;
                    end else if (i_sum[27]) begin
                        sum_d   = i_sum;
                        state_d = StRound;
                    end else begin
                        sum_d   = i_sum;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                if (exp_q > 9'd1) begin
                    sum_d = {sum_q[27:0], 1'b0};
                    exp_d = exp_q - 9'd1;
                    if (sum_q[26]) begin
                        state_d = StRound;
                    end
                end else begin
                    // Exponent exhausted before the mantissa normalized: flush to signed zero.
                    result_d = {sign_q, 31'b0};
                    udf_d    = 1'b1;
                    state_d  = StDone;
                end
            end
            StRound: begin
                if (exp_rnd >= 9'd255) begin
                    result_d = {sign_q, 8'hFF, 23'b0};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_rnd[7:0], frac_inc[22:0]};
                end
                state_d = StDone;
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        valid_d = (state_d == StDone);
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            sum_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_ovf    = ovf_q;
    assign o_udf    = udf_q;

endmodule

// File: tb/tb_unit_norm_round.sv
// Scoreboard bench for unit_norm_round: random and directed sums against an arithmetic model,
// with random downstream backpressure, a long stall and a reset that aborts a shift.
module tb_unit_norm_round;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [28:0] i_sum;
    logic [7:0]  i_exp;
    logic        i_sign;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_ovf;
    logic        o_udf;

    unit_norm_round dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sum    (i_sum),
        .i_exp    (i_exp),
        .i_sign   (i_sign),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_ovf    (o_ovf),
        .o_udf    (o_udf)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        udf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    logic stall   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Reference: find the leading one, normalize arithmetically, round the 4-bit tail
    // (above half rounds up, exactly half rounds to an even significand).
    function automatic exp_t model(input logic [28:0] s, input int e, input logic sg);
        exp_t r;
        longint unsigned m;
        longint unsigned sig;
        int ex;
        int p;
        int k;
        int tail;
        r.ovf = 1'b0;
        r.udf = 1'b0;
        r.acc = 0;
        if (s == 29'd0) begin
            r.res = 32'h0;
            r.lat = 1;
            return r;
        end
        p = 0;
        for (int i = 0; i < 29; i++) if (s[i]) p = i;
        m  = 64'(s);
        ex = e;
        if (p == 28) begin
            m     = (m >> 1) | (m & 64'd1);
            ex    = e + 1;
            r.lat = 2;
        end else begin
            k = 27 - p;
            if (k > 0 && e <= k) begin
                r.res = {sg, 31'b0};
                r.udf = 1'b1;
                r.lat = e + 1;
                return r;
            end
            m     = m << k;
            ex    = e - k;
            r.lat = 2 + k;
        end
        sig  = m >> 4;
        tail = int'(m & 64'd15);
        if (tail > 8 || (tail == 8 && sig[0])) sig = sig + 64'd1;
        if (sig >= (64'd1 << 24)) begin
            sig = sig >> 1;
            ex  = ex + 1;
        end
        if (ex >= 255) begin
            r.res = {sg, 8'hFF, 23'b0};
            r.ovf = 1'b1;
        end else begin
            r.res = {sg, 8'(ex), sig[22:0]};
        end
        return r;
    endfunction

    // Downstream readiness, changed just after each falling edge.
    initial begin
        i_ready = 1'b0;
        forever begin
            @(negedge i_clk);
            #1;
            i_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares a new result when it first appears, then checks it holds while stalled.
    initial begin
        exp_t        e;
        logic        fresh;
        logic [33:0] held;
        fresh = 1'b1;
        held  = '0;
        forever begin
            @(negedge i_clk);
            #2;
            if (!o_valid) begin
                fresh = 1'b1;
            end else begin
                check("ready_low_while_valid", 32'(o_ready), 32'd0);
                if (fresh) begin
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_output: got result %h, expected none", o_result);
                    end else begin
                        e = sb.pop_front();
                        check("result", o_result, e.res);
                        check("ovf", 32'(o_ovf), 32'(e.ovf));
                        check("udf", 32'(o_udf), 32'(e.udf));
                        check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    end
                end else begin
                    check("hold_outputs", 32'({o_ovf, o_udf, o_result} != held), 32'd0);
                end
                held  = {o_ovf, o_udf, o_result};
                fresh = i_ready;
            end
        end
    end

    task automatic send(input logic [28:0] s, input logic [7:0] e, input logic sg);
        exp_t x;
        bit   done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge i_clk);
            if (o_ready) begin
                i_valid = 1'b1;
                i_sum   = s;
                i_exp   = e;
                i_sign  = sg;
                x       = model(s, int'(e), sg);
                x.acc   = cyc + 1;
                sb.push_back(x);
                done    = 1'b1;
            end else begin
                // Junk while busy: must be ignored.
                i_valid = 1'($urandom_range(0, 1));
                i_sum   = 29'($urandom);
                i_exp   = 8'($urandom);
                i_sign  = 1'($urandom);
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL accept_timeout: o_ready stayed %b, expected 1", o_ready);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            t++;
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        logic [28:0] s;
        logic [7:0]  e;
        logic [31:0] r;
        int          nb;
        int          t;
        logic        seen;

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_sum   = '0;
        i_exp   = '0;
        i_sign  = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_result", o_result, 32'h0);
        check("rst_ovf", 32'(o_ovf), 32'd0);
        check("rst_udf", 32'(o_udf), 32'd0);

        stall = 1'b0;
        send(29'h1000_0000, 8'd127, 1'b0);
        send(29'h0000_0000, 8'd127, 1'b1);
        send(29'h0100_0000, 8'd127, 1'b0);
        send(29'h0800_0008, 8'd127, 1'b0);
        send(29'h0800_0018, 8'd127, 1'b0);
        send(29'h0FFF_FFF8, 8'd254, 1'b0);
        send(29'h0000_0010, 8'd3,   1'b1);
        send(29'h0400_0000, 8'd1,   1'b0);
        send(29'h1000_0000, 8'd254, 1'b1);
        send(29'h0000_0001, 8'd200, 1'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            nb = $urandom_range(0, 29);
            r  = $urandom;
            if (nb == 0) begin
                s = '0;
            end else begin
                s         = 29'(r & ((32'd1 << nb) - 32'd1));
                s[nb - 1] = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) s[3:0] = 4'b1000;
            case ($urandom_range(0, 3))
                0:       e = 8'($urandom_range(1, 8));
                1:       e = 8'($urandom_range(247, 254));
                default: e = 8'($urandom_range(1, 254));
            endcase
            send(s, e, 1'($urandom));
        end
        drain();
        idle(5);

        // Long stall: result and handshake must stay frozen.
        stall = 1'b1;
        send(29'h1000_0000, 8'd127, 1'b0);
        t = 0;
        while (!o_valid && t < 50) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            t++;
        end
        check("stall_reached_valid", 32'(o_valid), 32'd1);
        repeat (5) begin
            check("stall_result", o_result, 32'h4000_0000);
            check("stall_ready", 32'(o_ready), 32'd0);
            @(negedge i_clk);
        end
        stall = 1'b0;
        drain();
        idle(5);

        // Reset while shifting, with i_valid high during reset.
        send(29'h0000_0001, 8'd100, 1'b0);
        idle(6);
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_sum   = 29'h0800_0000;
        i_exp   = 8'd127;
        sb.delete();
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_result", o_result, 32'h0);
        check("abort_flags", 32'({o_ovf, o_udf}), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);

        send(29'h0800_0008, 8'd127, 1'b0);
        drain();
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
